// File: rtl/pa_pmp_resp_ctrl_pkg.sv
// rtl/pa_pmp_resp_ctrl_pkg.sv - shared constants and fault source encodings for the PMP response block
package pa_pmp_resp_ctrl_pkg;

    localparam int PMP_REGION_NUM = 8;
    localparam int PMP_IDX_W      = 3;

    typedef enum logic [1:0] {
        FSRC_NONE = 2'b00,
        FSRC_IFU  = 2'b01,
        FSRC_LD   = 2'b10,
        FSRC_ST   = 2'b11
    } pmp_fsrc_e;

endpackage

// File: rtl/pa_pmp_resp_chan.sv
// rtl/pa_pmp_resp_chan.sv - per-channel PMP priority resolve, response register and handshake
module pa_pmp_resp_chan
    import pa_pmp_resp_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int REGION_NUM = PMP_REGION_NUM,
    parameter bit IS_LSU     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_is_st,
    input  logic [REGION_NUM-1:0] region_hit,
    input  logic [REGION_NUM-1:0] deny_region,
    input  logic                  no_hit_deny,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic                  rsp_deny,
    output logic [PMP_IDX_W-1:0]  rsp_region,
    output logic                  rsp_hit,
    output logic                  cap_vld,
    output logic [1:0]            cap_src,
    output logic [ADDR_WIDTH-1:0] cap_addr,
    output logic [PMP_IDX_W-1:0]  cap_region,
    output logic                  cap_nohit
);

    logic [PMP_IDX_W-1:0] win_idx;
    logic                 win_deny;
    logic                 any_hit;
    logic                 deny_c;
    logic                 accept;

    // Scan downward so the lowest-index hit is the last one written.
    always_comb begin
        win_idx  = '0;
        win_deny = 1'b0;
        for (int i = REGION_NUM - 1; i >= 0; i--) begin
            if (region_hit[i]) begin
                win_idx  = PMP_IDX_W'(i);
                win_deny = deny_region[i];
            end
        end
    end

    assign any_hit = |region_hit;
    assign deny_c  = any_hit ? win_deny : no_hit_deny;
    assign req_rdy = !rsp_vld || rsp_rdy;
    assign accept  = req_vld && req_rdy;

    assign cap_vld    = accept && deny_c;
    assign cap_addr   = req_addr;
    assign cap_region = win_idx;
    assign cap_nohit  = !any_hit;
    assign cap_src    = !IS_LSU ? FSRC_IFU : (req_is_st ? FSRC_ST : FSRC_LD);

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld    <= 1'b0;
            rsp_deny   <= 1'b0;
            rsp_region <= '0;
            rsp_hit    <= 1'b0;
        end else if (accept) begin
            rsp_vld    <= 1'b1;
            rsp_deny   <= deny_c;
            rsp_region <= win_idx;
            rsp_hit    <= any_hit;
        end else if (rsp_rdy) begin
            rsp_vld    <= 1'b0;
        end
    end

endmodule

// File: rtl/pa_pmp_resp_ctrl.sv
// rtl/pa_pmp_resp_ctrl.sv - IFU/LSU PMP response control with sticky fault record; PMP_FAULT_CNT_EN adds fault_cnt
module pa_pmp_resp_ctrl
    import pa_pmp_resp_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int REGION_NUM = PMP_REGION_NUM
`ifdef PMP_FAULT_CNT_EN
    ,
    parameter int CNT_WIDTH  = 16
`endif
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  ifu_pmp_req_vld,
    output logic                  ifu_pmp_req_rdy,
    input  logic [ADDR_WIDTH-1:0] ifu_pmp_req_addr,
    input  logic [REGION_NUM-1:0] ifu_region_hit,
    input  logic [REGION_NUM-1:0] ifu_access_deny_region,
    input  logic                  ifu_access_no_hit_deny,
    output logic                  ifu_pmp_rsp_vld,
    input  logic                  ifu_pmp_rsp_rdy,
    output logic                  ifu_pmp_rsp_deny,
    output logic [2:0]            ifu_pmp_rsp_region,
    output logic                  ifu_pmp_rsp_hit,
    input  logic                  lsu_pmp_req_vld,
    output logic                  lsu_pmp_req_rdy,
    input  logic [ADDR_WIDTH-1:0] lsu_pmp_req_addr,
    input  logic [REGION_NUM-1:0] lsu_region_hit,
    input  logic [REGION_NUM-1:0] lsu_access_deny_region,
    input  logic                  lsu_access_no_hit_deny,
    input  logic                  lsu_pmp_is_st,
    output logic                  lsu_pmp_rsp_vld,
    input  logic                  lsu_pmp_rsp_rdy,
    output logic                  lsu_pmp_rsp_deny,
    output logic [2:0]            lsu_pmp_rsp_region,
    output logic                  lsu_pmp_rsp_hit,
    input  logic                  fault_clr,
    output logic                  fault_vld,
    output logic [1:0]            fault_src,
    output logic [ADDR_WIDTH-1:0] fault_addr,
    output logic [2:0]            fault_region,
    output logic                  fault_nohit,
`ifdef PMP_FAULT_CNT_EN
    output logic [CNT_WIDTH-1:0]  fault_cnt,
`endif
    output logic                  fault_ovf
);

    logic                  ifu_cap, lsu_cap;
    logic [1:0]            ifu_cap_src, lsu_cap_src;
    logic [ADDR_WIDTH-1:0] ifu_cap_addr, lsu_cap_addr;
    logic [2:0]            ifu_cap_region, lsu_cap_region;
    logic                  ifu_cap_nohit, lsu_cap_nohit;

    pa_pmp_resp_chan #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .REGION_NUM (REGION_NUM),
        .IS_LSU     (1'b0)
    ) u_ifu_chan (
        .clk         (forever_cpuclk),
        .rst         (cpurst),
        .req_vld     (ifu_pmp_req_vld),
        .req_rdy     (ifu_pmp_req_rdy),
        .req_addr    (ifu_pmp_req_addr),
        .req_is_st   (1'b0),
        .region_hit  (ifu_region_hit),
        .deny_region (ifu_access_deny_region),
        .no_hit_deny (ifu_access_no_hit_deny),
        .rsp_vld     (ifu_pmp_rsp_vld),
        .rsp_rdy     (ifu_pmp_rsp_rdy),
        .rsp_deny    (ifu_pmp_rsp_deny),
        .rsp_region  (ifu_pmp_rsp_region),
        .rsp_hit     (ifu_pmp_rsp_hit),
        .cap_vld     (ifu_cap),
        .cap_src     (ifu_cap_src),
        .cap_addr    (ifu_cap_addr),
        .cap_region  (ifu_cap_region),
        .cap_nohit   (ifu_cap_nohit)
    );

    pa_pmp_resp_chan #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .REGION_NUM (REGION_NUM),
        .IS_LSU     (1'b1)
    ) u_lsu_chan (
        .clk         (forever_cpuclk),
        .rst         (cpurst),
        .req_vld     (lsu_pmp_req_vld),
        .req_rdy     (lsu_pmp_req_rdy),
        .req_addr    (lsu_pmp_req_addr),
        .req_is_st   (lsu_pmp_is_st),
        .region_hit  (lsu_region_hit),
        .deny_region (lsu_access_deny_region),
        .no_hit_deny (lsu_access_no_hit_deny),
        .rsp_vld     (lsu_pmp_rsp_vld),
        .rsp_rdy     (lsu_pmp_rsp_rdy),
        .rsp_deny    (lsu_pmp_rsp_deny),
        .rsp_region  (lsu_pmp_rsp_region),
        .rsp_hit     (lsu_pmp_rsp_hit),
        .cap_vld     (lsu_cap),
        .cap_src     (lsu_cap_src),
        .cap_addr    (lsu_cap_addr),
        .cap_region  (lsu_cap_region),
        .cap_nohit   (lsu_cap_nohit)
    );

    // A clear in the same cycle as a new deny lets the deny land in an empty record.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            fault_vld    <= 1'b0;
            fault_src    <= FSRC_NONE;
            fault_addr   <= '0;
            fault_region <= '0;
            fault_nohit  <= 1'b0;
            fault_ovf    <= 1'b0;
        end else if (ifu_cap || lsu_cap) begin
            if (!fault_vld || fault_clr) begin
                fault_vld <= 1'b1;
                fault_ovf <= ifu_cap && lsu_cap;
                if (lsu_cap) begin
                    fault_src    <= lsu_cap_src;
                    fault_addr   <= lsu_cap_addr;
                    fault_region <= lsu_cap_region;
                    fault_nohit  <= lsu_cap_nohit;
                end else begin
                    fault_src    <= ifu_cap_src;
                    fault_addr   <= ifu_cap_addr;
                    fault_region <= ifu_cap_region;
                    fault_nohit  <= ifu_cap_nohit;
                end
            end else begin
                fault_ovf <= 1'b1;
            end
        end else if (fault_clr) begin
            fault_vld <= 1'b0;
            fault_ovf <= 1'b0;
        end
    end

`ifdef PMP_FAULT_CNT_EN
    logic [CNT_WIDTH:0] cnt_sum;

    assign cnt_sum = {1'b0, fault_cnt}
                   + {{CNT_WIDTH{1'b0}}, ifu_cap}
                   + {{CNT_WIDTH{1'b0}}, lsu_cap};

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            fault_cnt <= '0;
        end else if (cnt_sum[CNT_WIDTH]) begin
            fault_cnt <= '1;
        end else begin
            fault_cnt <= cnt_sum[CNT_WIDTH-1:0];
        end
    end
`endif

endmodule

// File: doc/pa_pmp_resp_ctrl.md
Name: pa_pmp_resp_ctrl

Overview:
Sits directly downstream of the PMP access-attribute arbiter. For each of the IFU and LSU channels it takes that arbiter's per-region deny vector and no-hit deny, plus the comparator's region-hit vector. It resolves the PMP priority (lowest-index hit wins), produces a registered permit/deny response with a valid/ready handshake, and captures the first denied access in sticky fault registers for CSR/debug readout.

Parameters:
ADDR_WIDTH, 32, width of the request address captured on a fault
REGION_NUM, 8, number of PMP entries (hit/deny vector width)
CNT_WIDTH, 16, width of the optional saturating fault counter

Ports:
forever_cpuclk  in  1  clock
cpurst  in  1  reset, synchronous, active-high
ifu_pmp_req_vld  in  1  IFU check request valid
ifu_pmp_req_rdy  out  1  IFU request accepted
ifu_pmp_req_addr  in  ADDR_WIDTH  IFU request address
ifu_region_hit  in  REGION_NUM  comparator hit per region, IFU
ifu_access_deny_region  in  REGION_NUM  per-region deny from attribute arbiter, IFU
ifu_access_no_hit_deny  in  1  deny when no region hits, IFU
ifu_pmp_rsp_vld  out  1  IFU response valid
ifu_pmp_rsp_rdy  in  1  IFU response consumed
ifu_pmp_rsp_deny  out  1  IFU access denied
ifu_pmp_rsp_region  out  3  winning region index (0 if no hit)
ifu_pmp_rsp_hit  out  1  any region hit
lsu_pmp_req_vld / lsu_pmp_req_rdy / lsu_pmp_req_addr / lsu_region_hit / lsu_access_deny_region / lsu_access_no_hit_deny  same as IFU, LSU side
lsu_pmp_is_st  in  1  LSU request is a store, qualified by lsu_pmp_req_vld
lsu_pmp_rsp_vld / lsu_pmp_rsp_rdy / lsu_pmp_rsp_deny / lsu_pmp_rsp_region / lsu_pmp_rsp_hit  same as IFU, LSU side
fault_clr  in  1  pulse; clears the sticky fault record
fault_vld  out  1  fault record holds a fault
fault_src  out  2  01 = IFU, 10 = LSU-load, 11 = LSU-store
fault_addr  out  ADDR_WIDTH  address of the captured fault
fault_region  out  3  region index of the captured fault
fault_nohit  out  1  captured fault came from the no-hit deny
fault_ovf  out  1  another deny occurred while fault_vld was set

Behaviour:
- Reset: every *_rsp_vld = 0, deny/region/hit = 0, all fault_* = 0; req_rdy = 1 from the first cycle after reset.
- Per channel, one-stage registered pipeline: req_rdy = !rsp_vld || rsp_rdy. Accept = req_vld && req_rdy.
- On accept, the response appears on the next cycle, latency 1. Full throughput back-to-back when rsp_rdy is held high.
- Priority: idx = lowest i with hit[i] = 1. deny = hit ? deny_region[idx] : no_hit_deny. Higher-index deny bits are ignored when a lower index hits.
- When rsp_vld && !rsp_rdy, all rsp outputs stay stable and no new request is accepted.
- Request-side inputs are sampled only on accept.
- Fault capture fires on a registered deny at accept time (one event per accepted denied request).
- If fault_vld = 0: record src/addr/region/nohit and set fault_vld.
- If fault_vld = 1: set fault_ovf; the record is unchanged.
- Simultaneous IFU and LSU deny with fault_vld = 0: LSU is recorded and fault_ovf is set.
- fault_clr: clears fault_vld and fault_ovf. If a deny is captured in the same cycle, that new deny is recorded and fault_ovf = 0 (capture wins over clear).
- Reset mid-transaction drops any pending response. No response is emitted for a request that was in flight.

Optional Feature:
PMP_FAULT_CNT_EN.
- Defined: adds output fault_cnt [CNT_WIDTH-1:0], the count of denied accepts. +1 per channel deny; +2 when both channels deny in the same cycle. Saturates at all-ones. Cleared by reset only, not by fault_clr.
- Undefined: no port, no counter logic.

Decomposition:
- Shared package: REGION_NUM default, region index width (3), fault_src encodings (FSRC_IFU = 2'b01, FSRC_LD = 2'b10, FSRC_ST = 2'b11).
- One sub-module pa_pmp_resp_chan, instantiated twice: priority encoder + response register + handshake. It exports a capture strobe and the captured fields.
- Fault record and optional counter live in the top level.

Test Plan:
- IFU req, hit = 8'b0000_0110, deny = 8'b0000_0100 -> next cycle rsp_vld = 1, region = 1, hit = 1, deny = 0; no fault recorded.
- LSU store, hit = 0, no_hit_deny = 1, addr = 0x2000_0010 -> deny = 1, fault_vld = 1, src = 11, nohit = 1, addr = 0x2000_0010.
- LSU rsp_rdy = 0 for 3 cycles with a new req_vld pending -> req_rdy = 0, rsp outputs stable; request accepted in the cycle rsp_rdy rises, response on the next cycle.
- IFU and LSU both deny in the same cycle from empty record -> src = 10/11 (LSU), fault_ovf = 1; with PMP_FAULT_CNT_EN, fault_cnt += 2.
- fault_clr in the same cycle as a new IFU deny at region 5 -> fault_vld = 1, src = 01, region = 5, fault_ovf = 0.
- cpurst asserted while rsp_vld = 1 -> next cycle rsp_vld = 0, all fault_* = 0, req_rdy = 1.
